wb_ps2: RTL and testbench

WB_PS2 -- requirements
Module: wb_ps2

---
 rtl/wb_ps2_if.sv | 22 ++
 rtl/wb_ps2.sv | 176 +++++++++++++++++
 tb/tb_wb_ps2.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_ps2_if.sv
// Wishbone classic slave bus bundle for the PS/2 receiver.
// The signal names follow Wishbone slave-side naming (_i into the slave, _o out of it).
interface wb_ps2_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_ps2.sv
// PS/2 device-to-host receiver with an 8-entry byte FIFO behind a Wishbone slave.
// Registers: DATA (adr[2]=0) pops the FIFO, STATUS (adr[2]=1) reports and clears errors.
module wb_ps2 #(
  parameter int clk_freq = 50000000,
  parameter int fifo_aw  = 3
) (
  input  logic     clk,
  input  logic     reset_n,
  wb_ps2_if.slave  wb,
  input  logic     ps2_clk,
  input  logic     ps2_dat,
  output logic     intr
);

  localparam int DEPTH  = 1 << fifo_aw;
  localparam int CW     = fifo_aw + 1;
  localparam int TO_CYC = clk_freq / 5000;
  localparam int TO_W   = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_clk_s, r_dat_s;
  logic                 r_clk_d;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_cnt;
  logic                 r_parity;
  logic [TO_W-1:0]      r_to_cnt;
  logic [7:0]           r_mem [DEPTH];
  logic [fifo_aw-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count, w_count_nxt;
  logic                 r_ferr, r_perr, r_ovf;
  logic                 r_ack, r_pop_pend, r_intr;
  logic [31:0]          r_dat_o, w_rd_data;

  logic w_bit_evt, w_dat, w_timeout;
  logic w_push_req, w_push, w_pop, w_ferr_set, w_perr_set, w_ovf_set;
  logic w_full, w_not_empty, w_req, w_clr, w_unused;

  assign w_unused = ^{wb.wb_sel_i, wb.wb_adr_i[31:3], wb.wb_adr_i[1:0],
                      wb.wb_dat_i[31:5], wb.wb_dat_i[1:0]};

  // Synchronizers idle high so reset never manufactures a falling PS/2 clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_clk_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, forming a real shift chain.
      r_clk_s <= {r_clk_s[0], ps2_clk};
      r_dat_s <= {r_dat_s[0], ps2_dat};
      r_clk_d <= r_clk_s[1];
    end
  end

  assign w_bit_evt = r_clk_d & ~r_clk_s[1];
  assign w_dat     = r_dat_s[1];
  assign w_timeout = (r_state != S_IDLE) && !w_bit_evt && (r_to_cnt == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    w_perr_set  = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_ferr_set  = 1'b1;
    end else if (w_bit_evt) begin
      case (r_state)
        S_IDLE:   if (!w_dat) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          w_ferr_set  = !w_dat;
          w_perr_set  = !(^{r_shift, r_parity});
          w_push_req  = w_dat && (^{r_shift, r_parity});
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_to_cnt <= (r_state == S_IDLE || w_bit_evt || w_timeout) ? '0 : r_to_cnt + 1'b1;
      if (w_bit_evt) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          S_PARITY: r_parity <= w_dat;
          default:  ;
        endcase
      end
    end
  end

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_push      = w_push_req & ~w_full;
  assign w_ovf_set   = w_push_req & w_full;
  assign w_pop       = r_pop_pend;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: ;
    endcase
  end

  // NOTE: storage has no reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_intr   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_intr  <= (w_count_nxt != '0);
    end
  end

  assign w_req = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
  assign w_clr = w_req & wb.wb_we_i & wb.wb_adr_i[2];
  assign w_rd_data = wb.wb_adr_i[2]
                   ? {27'b0, r_ferr, r_perr, r_ovf, w_full, w_not_empty}
                   : (w_not_empty ? {24'b0, r_mem[r_rd_ptr]} : 32'b0);

  // The pop is decided when the data is captured, so a byte is never popped unseen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack      <= 1'b0;
      r_dat_o    <= '0;
      r_pop_pend <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_ack      <= w_req;
      r_dat_o    <= (w_req && !wb.wb_we_i) ? w_rd_data : 32'b0;
      r_pop_pend <= w_req && !wb.wb_we_i && !wb.wb_adr_i[2] && w_not_empty;
      r_ferr     <= w_ferr_set | (r_ferr & ~(w_clr & wb.wb_dat_i[4]));
      r_perr     <= w_perr_set | (r_perr & ~(w_clr & wb.wb_dat_i[3]));
      r_ovf      <= w_ovf_set  | (r_ovf  & ~(w_clr & wb.wb_dat_i[2]));
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat_o;
  assign intr        = r_intr;

endmodule

// File: tb/tb_wb_ps2.sv
// Directed bench for wb_ps2: PS/2 frames are bit-banged and results read over Wishbone.
module tb_wb_ps2;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic intr;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_ps2_if bus ();

  wb_ps2 #(.clk_freq(50000000), .fifo_aw(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (bus),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .intr    (intr)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par);
    logic par;
    par = ~(^d) ^ bad_par;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_dat = bits[i];
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output int lat);
    logic got;
    got  = 1'b0;
    rdat = '0;
    lat  = -1;
    @(negedge clk);
    bus.wb_adr_i = adr;
    bus.wb_dat_i = wdat;
    bus.wb_we_i  = we;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o) begin
        got  = 1'b1;
        rdat = bus.wb_dat_o;
        lat  = i;
      end
    end
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    if (!got) check("wb_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] rdat);
    int lat;
    wb_xfer(1'b0, adr, 32'h0, rdat, lat);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    int lat;
    wb_xfer(1'b1, adr, wdat, dummy, lat);
  endtask

  initial begin
    logic [31:0] v;
    int lat;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = 4'hF;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    reset_n = 1'b1;

    // Reset state and access timing
    wb_xfer(1'b0, 32'h4, 32'h0, v, lat);
    check("rst_status", v, 32'h00);
    check("ack_latency", 32'(lat), 32'd0);
    @(posedge clk); #1;
    check("ack_one_clock", 32'(bus.wb_ack_o), 32'd0);
    check("dat_idle_zero", bus.wb_dat_o, 32'h0);

    // Valid frame 0x1C
    send_bits(frame(8'h1C, 1'b0), 11);
    check("valid_intr", 32'(intr), 32'd1);
    rd(32'h4, v); check("valid_status", v, 32'h01);
    rd(32'h0, v); check("valid_data", v, 32'h1C);
    rd(32'h4, v); check("valid_status_after", v, 32'h00);
    check("valid_intr_after", 32'(intr), 32'd0);

    // Parity error, then clear via STATUS write; DATA write ignored
    send_bits(frame(8'h1C, 1'b1), 11);
    rd(32'h4, v); check("perr_status", v, 32'h08);
    wr(32'h0, 32'hFF);
    rd(32'h4, v); check("data_write_ignored", v, 32'h08);
    wr(32'h4, 32'h08);
    rd(32'h4, v); check("perr_cleared", v, 32'h00);

    // Overflow
    for (int i = 1; i <= 9; i++) send_bits(frame(8'(i), 1'b0), 11);
    rd(32'h4, v); check("ovf_status", v, 32'h07);
    for (int i = 1; i <= 8; i++) begin
      rd(32'h0, v); check($sformatf("ovf_data%0d", i), v, 32'(i));
    end
    rd(32'h0, v); check("empty_read", v, 32'h00);
    rd(32'h4, v); check("ovf_sticky", v, 32'h04);
    wr(32'h4, 32'h1C);

    // Timeout after start + 4 data bits
    send_bits(frame(8'h3A, 1'b0), 5);
    repeat (10500) @(negedge clk);
    rd(32'h4, v); check("timeout_status", v, 32'h10);
    send_bits(frame(8'h55, 1'b0), 11);
    rd(32'h0, v); check("timeout_recover", v, 32'h55);
    wr(32'h4, 32'h10);
    rd(32'h4, v); check("timeout_cleared", v, 32'h00);

    // Push of 0x22 lands in the same clock as the pop of 0x11
    send_bits(frame(8'h11, 1'b0), 11);
    begin
      logic [10:0] f;
      f = frame(8'h22, 1'b0);
      send_bits(f, 10);
      @(negedge clk);
      ps2_dat = f[10];
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      @(negedge clk);
      bus.wb_adr_i = 32'h0;
      bus.wb_we_i  = 1'b0;
      bus.wb_stb_i = 1'b1;
      bus.wb_cyc_i = 1'b1;
      @(posedge clk); #1;
      check("overlap_ack", 32'(bus.wb_ack_o), 32'd1);
      check("overlap_old_byte", bus.wb_dat_o, 32'h11);
      bus.wb_stb_i = 1'b0;
      bus.wb_cyc_i = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rd(32'h4, v); check("overlap_count1", v, 32'h01);
    rd(32'h0, v); check("overlap_new_byte", v, 32'h22);
    rd(32'h4, v); check("overlap_empty", v, 32'h00);

    // Reset mid-frame with three bytes queued and a read in flight
    for (int i = 0; i < 3; i++) send_bits(frame(8'hA0 + 8'(i), 1'b0), 11);
    check("pre_reset_intr", 32'(intr), 32'd1);
    send_bits(frame(8'h5A, 1'b0), 5);
    @(negedge clk);
    bus.wb_adr_i = 32'h4;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("reset_intr", 32'(intr), 32'd0);
    check("reset_ack", 32'(bus.wb_ack_o), 32'd0);
    check("reset_dat", bus.wb_dat_o, 32'h0);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd(32'h4, v); check("post_reset_status", v, 32'h00);
    send_bits(frame(8'hA5, 1'b0), 11);
    rd(32'h0, v); check("post_reset_frame", v, 32'hA5);
    rd(32'h4, v); check("post_reset_empty", v, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "bench timeout");
  end
endmodule
